fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Sequences the instruction-fetch datapath: owns the program counter, issues requests to a variable-latency instruction memory, and presents fetched instructions to decode over a valid/ready handshake.
- Handles control-flow redirects (branch/jump/flush) at any point in a fetch, including while a memory request is outstanding.
- Replaces the free-running PC register in the fetch stage once the core moves to multi-cycle memory and stalling decode.

Parameters:
- XLEN, 64, address/PC width
- INST_W, 32, instruction width
- RESET_PC, 64'h0, first fetch address after reset

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high reset
- imem_req  output  1  memory request; held high until imem_ack
- imem_addr  output  XLEN  request address; stable while imem_req is high
- imem_ack  input  1  memory response valid; may assert in the same cycle as imem_req (zero-wait)
- imem_rdata  input  INST_W  instruction data, valid when imem_ack
- redirect_valid  input  1  one-cycle pulse: restart fetch at redirect_pc
- redirect_pc  input  XLEN  redirect target
- if_valid  output  1  fetched instruction available to decode
- if_ready  input  1  decode accepts the instruction this cycle
- if_pc  output  XLEN  PC of the presented instruction
- if_inst  output  INST_W  presented instruction
- if_pc4  output  XLEN  if_pc + 4

Behaviour:
- Reset: clk is the clock; reset is asynchronous, active-high.
  - Reset values: state=IDLE, pc=RESET_PC, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=0, if_pc4=0, kill target=0.
  - Reset asserted mid-request abandons it. A late imem_ack after reset is ignored, because the controller only samples ack in BUSY/DRAIN.
- States:
  - IDLE: imem_req=0. Next cycle goes to BUSY.
  - BUSY: imem_req=1, imem_addr=pc.
    - ack and no redirect: capture if_inst=imem_rdata, if_pc=pc, if_pc4=pc+4, if_valid=1; pc<=pc+4; go to HOLD.
    - No ack: stay in BUSY.
  - HOLD: imem_req=0, if_valid=1, outputs held stable.
    - if_ready=1: if_valid<=0; go to BUSY; the next request is at the new pc.
  - DRAIN: an outstanding request must be discarded. imem_req=1, imem_addr unchanged until ack.
    - On ack: data dropped, pc<=target, go to BUSY.
- Redirect handling (target = {redirect_pc[XLEN-1:2], 2'b00}; low bits are forced to zero):
  - IDLE: pc<=target; go to BUSY.
  - BUSY with ack in the same cycle: response dropped, if_valid stays 0, pc<=target, stay in BUSY.
  - BUSY without ack: store target; go to DRAIN.
  - DRAIN: the stored target is overwritten (latest redirect wins). If ack arrives in the same cycle, go to BUSY at the new target.
  - HOLD: if_valid<=0, held instruction discarded, pc<=target, go to BUSY.
    - A handshake coinciding with a redirect (if_valid & if_ready & redirect_valid) is void; decode squashes it.
- Redirect has priority over every other transition.
- Throughput: at most one instruction per 2 cycles with a zero-wait memory.
  - Latency from entering BUSY with ack to if_valid: 1 cycle.
- Arithmetic: pc+4 is modulo 2^XLEN, so 64'hFFFF_FFFF_FFFF_FFFC wraps to 0 with no flag.
- imem_addr never changes while imem_req=1 and ack has not been seen.

Test Plan:
- Reset then zero-wait memory (ack tied to req), if_ready=1 → imem_addr sequence 0,4,8,C; if_valid pulses every 2nd cycle; if_pc4=if_pc+4.
- Memory with 3-cycle ack latency, if_ready=0 for 5 cycles after first fetch → imem_req high 3 cycles with addr=0; if_valid=1 and if_inst held stable until ready; next request at addr 4.
- Redirect to 64'h100 during HOLD while if_ready=1 → if_valid drops next cycle; next imem_addr=100; following instruction has if_pc=100.
- Redirect to 64'h200 while a request to 8 is outstanding (no ack) → enters DRAIN; addr stays 8 until ack; that data never appears on if_inst; next request at 200.
- Two redirects in DRAIN (64'h300, then 64'h403) → fetch resumes at 400 (latest target, low bits cleared).
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, zero-wait → first if_pc4=0, second fetch address 0; async reset mid-BUSY → all outputs reset immediately without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, issues one instruction-memory request at a time and hands each instruction to decode.
// Latency: 1 cycle from an acked request to if_valid. Backpressure: an instruction is held until if_ready; redirects squash it.
module fetch_sequencer #(
    parameter int              XLEN     = 64,
    parameter int              INST_W   = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [XLEN-1:0]   imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [XLEN-1:0]   if_pc,
    output logic [INST_W-1:0] if_inst,
    output logic [XLEN-1:0]   if_pc4
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   pc_nxt;
    logic [XLEN-1:0]   kill_pc;
    logic [XLEN-1:0]   kill_pc_nxt;
    logic [XLEN-1:0]   redir_tgt;
    logic              capture;
    logic              release_inst;
    logic              unused_low;

    // Fetch addresses are word aligned; the low target bits are dropped.
    assign redir_tgt  = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_low = ^redirect_pc[1:0];

    // pc is the address of the outstanding request, so it doubles as imem_addr.
    assign imem_req  = (state == BUSY) || (state == DRAIN);
    assign imem_addr = pc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        kill_pc_nxt  = kill_pc;
        capture      = 1'b0;
        release_inst = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = BUSY;
                if (redirect_valid) begin
                    pc_nxt = redir_tgt;
                end
            end
            BUSY: begin
                if (redirect_valid) begin
                    if (imem_ack) begin
                        pc_nxt = redir_tgt;
                    end else begin
                        kill_pc_nxt = redir_tgt;
                        state_nxt   = DRAIN;
                    end
                end else if (imem_ack) begin
                    capture   = 1'b1;
                    pc_nxt    = pc + XLEN'(4);
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    release_inst = 1'b1;
                    pc_nxt       = redir_tgt;
                    state_nxt    = BUSY;
                end else if (if_ready) begin
                    release_inst = 1'b1;
                    state_nxt    = BUSY;
                end
            end
            DRAIN: begin
                // The in-flight response belongs to the squashed path; wait it out, then restart.
                if (redirect_valid) begin
                    kill_pc_nxt = redir_tgt;
                end
                if (imem_ack) begin
                    pc_nxt    = redirect_valid ? redir_tgt : kill_pc;
                    state_nxt = BUSY;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc       <= RESET_PC;
            kill_pc  <= '0;
            if_valid <= 1'b0;
            if_pc    <= '0;
            if_inst  <= '0;
            if_pc4   <= '0;
        end else begin
            pc      <= pc_nxt;
            kill_pc <= kill_pc_nxt;
            if (capture) begin
                if_valid <= 1'b1;
                if_pc    <= pc;
                if_inst  <= imem_rdata;
                if_pc4   <= pc + XLEN'(4);
            end else if (release_inst) begin
                if_valid <= 1'b0;
            end
        end
    end

endmodule
